line_fifo_ctrl: RTL and testbench

// - Sequences the convolver's line_fifo chain for one image: configures the row length, then gates per-pixel shifting.
// - Tracks row/column position and flags the pixels at which a complete KxK window is present at the FIFO taps.
// - Sits between the pixel source (valid/ready) and the K-1 line_fifo instances plus the window MAC.

---
 rtl/conv_pkg.sv | 15 +
 rtl/lfc_pos_counter.sv | 40 ++++
 rtl/line_fifo_ctrl.sv | 101 ++++++++++
 tb/tb_line_fifo_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolver line-buffer slice.
// Holds the line_fifo controller state encoding and sizing defaults.
package conv_pkg;

   localparam int ADDR_FIFO     = 12;
   localparam int CONFIG_CYCLES = 2;

   typedef enum logic [1:0] {
      IDLE,
      CONFIG,
      STREAM,
      DONE
   } lfc_state_t;

endpackage

// File: rtl/lfc_pos_counter.sv
// Column/row position counter for one image.
// Wraps column at width-1 and row at height-1; last marks the final pixel.
module lfc_pos_counter #(
   parameter int CNT_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] width,
   input  logic [CNT_W-1:0] height,
   output logic [CNT_W-1:0] col,
   output logic [CNT_W-1:0] row,
   output logic             last
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic col_end;
   logic row_end;

   assign col_end = (col == width - ONE);
   assign row_end = (row == height - ONE);
   assign last    = col_end & row_end;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         col <= '0;
         row <= '0;
      end else if (en) begin
         if (col_end) begin
            col <= '0;
            row <= row_end ? '0 : row + ONE;
         end else begin
            col <= col + ONE;
         end
      end
   end

endmodule

// File: rtl/line_fifo_ctrl.sv
// Sequences the line_fifo chain for one image and flags pixels
// where a complete KxK window is present at the FIFO taps.
module line_fifo_ctrl
   import conv_pkg::*;
#(
   parameter int K     = 3,
   parameter int CNT_W = ADDR_FIFO
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] cfg_width,
   input  logic [CNT_W-1:0] cfg_height,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             fifo_reset,
   output logic [CNT_W-1:0] row_length,
   output logic             shifting,
   output logic             win_valid,
   output logic [CNT_W-1:0] col_idx,
   output logic [CNT_W-1:0] row_idx,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   localparam logic [CNT_W-1:0] KK  = CNT_W'(K);
   localparam logic [CNT_W-1:0] KM1 = CNT_W'(K - 1);
   localparam logic [1:0]       CFG_LAST = 2'(CONFIG_CYCLES - 1);

   lfc_state_t       state_q;
   lfc_state_t       state_d;
   logic [CNT_W-1:0] w_q;
   logic [CNT_W-1:0] h_q;
   logic [1:0]       cfg_cnt_q;
   logic             accept;
   logic             bad_cfg;
   logic             last;

   assign bad_cfg = (cfg_width < KK) || (cfg_height < KK);
   assign accept  = (state_q == IDLE) && start && !abort;

   assign pix_ready  = (state_q == STREAM) && !abort;
   assign shifting   = pix_valid && pix_ready;
   assign fifo_reset = (state_q == CONFIG);
   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign row_length = w_q;
   assign win_valid  = shifting && (row_idx >= KM1) && (col_idx >= KM1);

   lfc_pos_counter #(
      .CNT_W(CNT_W)
   ) u_pos (
      .clk   (clk),
      .rst   (rst),
      .clr   (accept || abort),
      .en    (shifting),
      .width (w_q),
      .height(h_q),
      .col   (col_idx),
      .row   (row_idx),
      .last  (last)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = bad_cfg ? DONE : CONFIG;
         CONFIG: begin
            if (abort)                       state_d = IDLE;
            else if (cfg_cnt_q == CFG_LAST) state_d = STREAM;
         end
         STREAM: begin
            if (abort)                 state_d = IDLE;
            else if (shifting && last) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         w_q       <= '0;
         h_q       <= '0;
         cfg_cnt_q <= '0;
         cfg_err   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cfg_cnt_q <= (state_q == CONFIG) ? cfg_cnt_q + 2'd1 : 2'd0;
         if (accept) begin
            w_q     <= cfg_width;
            h_q     <= cfg_height;
            cfg_err <= bad_cfg;
         end
      end
   end

endmodule

// File: tb/tb_line_fifo_ctrl.sv
// Self-checking bench for line_fifo_ctrl against a shift-count model.
// Directed scenarios with randomized pix_valid stalls.
module tb_line_fifo_ctrl;

   localparam int K  = 3;
   localparam int CW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [CW-1:0] cfg_width = '0;
   logic [CW-1:0] cfg_height = '0;
   logic          pix_valid = 1'b0;
   logic          pix_ready;
   logic          fifo_reset;
   logic [CW-1:0] row_length;
   logic          shifting;
   logic          win_valid;
   logic [CW-1:0] col_idx;
   logic [CW-1:0] row_idx;
   logic          busy;
   logic          done;
   logic          cfg_err;

   always #5 clk = ~clk;

   line_fifo_ctrl #(
      .K    (K),
      .CNT_W(CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .cfg_width (cfg_width),
      .cfg_height(cfg_height),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .fifo_reset(fifo_reset),
      .row_length(row_length),
      .shifting  (shifting),
      .win_valid (win_valid),
      .col_idx   (col_idx),
      .row_idx   (row_idx),
      .busy      (busy),
      .done      (done),
      .cfg_err   (cfg_err)
   );

   int checks = 0;
   int failures = 0;

   // model: phase 0 idle, 1 config, 2 stream, 3 done; m_n = shifts so far
   int m_phase = 0;
   int m_cfg_left = 0;
   int m_n = 0;
   int m_W = 0;
   int m_H = 0;
   bit m_err = 0;

   int cyc_no = 0;
   int st_shift, st_win, st_frst, st_done;
   int last_shift_cyc, done_cyc;
   bit seen_done;
   int win_q[$];
   int nom_q[$];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      cyc_no++;
      if (rst) begin
         m_phase = 0; m_n = 0; m_W = 0; m_H = 0; m_err = 0;
      end else begin
         case (m_phase)
            0: if (!abort && start) begin
               m_W = int'(cfg_width);
               m_H = int'(cfg_height);
               m_err = (m_W < K) || (m_H < K);
               m_phase = m_err ? 3 : 1;
               m_cfg_left = 2;
               m_n = 0;
            end
            1: if (abort) begin
               m_phase = 0; m_n = 0;
            end else begin
               m_cfg_left--;
               if (m_cfg_left == 0) m_phase = 2;
            end
            2: if (abort) begin
               m_phase = 0; m_n = 0;
            end else if (pix_valid) begin
               m_n++;
               if (m_n == m_W * m_H) begin
                  m_phase = 3; m_n = 0;
               end
            end
            default: m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin : compare
      int col, row;
      bit rdy, sh, wv;
      rdy = (m_phase == 2) && !abort;
      sh  = rdy && pix_valid;
      col = (m_W == 0) ? 0 : m_n % m_W;
      row = (m_W == 0) ? 0 : m_n / m_W;
      wv  = sh && (row >= K - 1) && (col >= K - 1);
      chk("pix_ready", 32'(pix_ready), 32'(rdy));
      chk("shifting", 32'(shifting), 32'(sh));
      chk("win_valid", 32'(win_valid), 32'(wv));
      chk("fifo_reset", 32'(fifo_reset), 32'(m_phase == 1));
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("row_length", 32'(row_length), 32'(m_W));
      if (m_phase == 2) begin
         chk("col_idx", 32'(col_idx), 32'(col));
         chk("row_idx", 32'(row_idx), 32'(row));
      end
      if (sh) begin
         st_shift++;
         last_shift_cyc = cyc_no;
      end
      if (wv) begin
         st_win++;
         win_q.push_back(row * 100 + col);
      end
      if (m_phase == 1) st_frst++;
      if (m_phase == 3) begin
         st_done++;
         seen_done = 1;
         done_cyc = cyc_no;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      st_shift = 0; st_win = 0; st_frst = 0; st_done = 0;
      last_shift_cyc = 0; done_cyc = 0; seen_done = 0;
      win_q.delete();
   endtask

   task automatic start_img(int w, int h);
      cfg_width = CW'(w);
      cfg_height = CW'(h);
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   task automatic run_done(int maxc, bit rnd);
      for (int i = 0; i < maxc; i++) begin
         pix_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         cyc();
         if (seen_done) break;
      end
      pix_valid = 1'b0;
      if (!seen_done) begin
         failures++;
         $display("FAIL run_timeout: got no done within %0d cycles", maxc);
      end
   endtask

   initial begin
      bit same;
      bit hit;
      clr_stats();
      cyc();
      cyc();
      rst = 1'b0;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_row_length", 32'(row_length), 0);
      chk("rst_cfg_err", 32'(cfg_err), 0);
      chk("rst_col", 32'(col_idx), 0);
      cyc();

      // nominal
      clr_stats();
      start_img(5, 4);
      run_done(100, 0);
      chk("nom_shifts", st_shift, 20);
      chk("nom_wins", st_win, 6);
      chk("nom_fifo_reset", st_frst, 2);
      chk("nom_done", st_done, 1);
      chk("nom_done_lat", done_cyc - last_shift_cyc, 1);
      chk("nom_first_win", (win_q.size() > 0) ? win_q[0] : -1, 202);
      chk("nom_last_win", (win_q.size() == 6) ? win_q[5] : -1, 304);
      nom_q = win_q;
      cyc();

      // random stalls
      clr_stats();
      start_img(5, 4);
      run_done(500, 1);
      chk("stall_shifts", st_shift, 20);
      chk("stall_wins", st_win, 6);
      same = (win_q.size() == nom_q.size());
      if (same) foreach (win_q[i]) if (win_q[i] != nom_q[i]) same = 0;
      chk("stall_seq_equal", 32'(same), 1);
      cyc();

      // bad cfg
      clr_stats();
      start_img(2, 8);
      run_done(10, 0);
      chk("bad_cfg_err", 32'(cfg_err), 1);
      chk("bad_fifo_reset", st_frst, 0);
      chk("bad_shifts", st_shift, 0);
      chk("bad_done", st_done, 1);
      clr_stats();
      start_img(5, 4);
      chk("bad_err_cleared", 32'(cfg_err), 0);
      run_done(100, 0);
      cyc();

      // abort at shift 30
      clr_stats();
      start_img(8, 8);
      hit = 0;
      for (int i = 0; i < 200; i++) begin
         pix_valid = 1'b1;
         if (st_shift == 30) begin
            abort = 1'b1;
            cyc();
            abort = 1'b0;
            hit = 1;
            break;
         end
         cyc();
      end
      pix_valid = 1'b0;
      chk("abort_reached", 32'(hit), 1);
      chk("abort_idle", 32'(busy), 0);
      cyc();
      cyc();
      chk("abort_shifts", st_shift, 30);
      chk("abort_no_done", st_done, 0);
      clr_stats();
      start_img(8, 8);
      chk("rerun_col0", 32'(col_idx), 0);
      chk("rerun_row0", 32'(row_idx), 0);
      run_done(200, 1);
      chk("rerun_shifts", st_shift, 64);
      chk("rerun_wins", st_win, 36);
      chk("rerun_fifo_reset", st_frst, 2);
      cyc();

      // reset mid-stream
      clr_stats();
      start_img(6, 6);
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         pix_valid = 1'b1;
         if (st_shift == 10) begin
            hit = 1;
            break;
         end
         cyc();
      end
      chk("rst_reached", 32'(hit), 1);
      pix_valid = 1'b0;
      rst = 1'b1;
      start = 1'b1;
      cfg_width = CW'(5);
      cfg_height = CW'(4);
      cyc();
      chk("mrst_busy", 32'(busy), 0);
      chk("mrst_row_length", 32'(row_length), 0);
      chk("mrst_col", 32'(col_idx), 0);
      cyc();
      rst = 1'b0;
      start = 1'b0;
      cyc();
      chk("mrst_start_ignored", 32'(busy), 0);

      // back-to-back
      clr_stats();
      start_img(5, 4);
      hit = 0;
      for (int i = 0; i < 100; i++) begin
         pix_valid = 1'b1;
         if (m_phase == 3) begin
            hit = 1;
            break;
         end
         cyc();
      end
      pix_valid = 1'b0;
      chk("b2b_done_reached", 32'(hit), 1);
      cfg_width = CW'(6);
      cfg_height = CW'(3);
      start = 1'b1;
      cyc();
      chk("b2b_ignored_in_done", 32'(busy), 0);
      cyc();
      start = 1'b0;
      chk("b2b_accepted", 32'(busy), 1);
      chk("b2b_row_length", 32'(row_length), 6);
      clr_stats();
      run_done(100, 0);
      chk("b2b_shifts", st_shift, 18);
      chk("b2b_wins", st_win, 4);
      chk("b2b_fifo_reset", st_frst, 2);
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
